// File: rtl/comunicaciones_rx.sv
// 8N1 UART receiver with LF-terminated line assembly and response-string classification.
// byte_valid one cycle after the stop-bit sample, resp_valid two cycles after the LF byte; no backpressure.
module comunicaciones_rx #(
  parameter int BAUD   = 434,
  parameter int MAXLEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [2:0] resp_code,
  output logic       resp_valid,
  output logic       busy
);

  localparam int CW = $clog2(BAUD);
  localparam int LW = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BAUD - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAXLEN);

  // Table strings are left-aligned so character i always sits at bits [55-8i -: 8].
  localparam logic [55:0] S_OK    = {"OK", 40'd0};
  localparam logic [55:0] S_ERROR = {"ERROR", 16'd0};
  localparam logic [55:0] S_READY = {"ready", 16'd0};
  localparam logic [55:0] S_SEND  = "SEND OK";
  localparam logic [55:0] S_FAIL  = {"FAIL", 24'd0};

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t              state, state_n;
  logic                rx_m, rxs;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic                ld_half, ld_full, shift_en, byte_done, ferr;
  logic [MAXLEN*8-1:0] line_buf;
  logic [LW-1:0]       len;
  logic                ovf, match_pend;
  logic [2:0]          code;

  function automatic logic str_eq(input logic [55:0] s, input int n,
                                  input logic [LW-1:0] l, input logic [MAXLEN*8-1:0] b);
    logic r;
    r = (int'(l) == n);
    for (int i = 0; i < 7; i++)
      if (i < n && b[8*i +: 8] != s[55-8*i -: 8]) r = 1'b0;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  always_comb begin
    state_n   = state;
    ld_half   = 1'b0;
    ld_full   = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE:  if (!rxs) begin state_n = START; ld_half = 1'b1; end
      START: if (cnt == '0) begin
               if (rxs) state_n = IDLE;
               else begin state_n = DATA; ld_full = 1'b1; end
             end
      DATA:  if (cnt == '0) begin
               shift_en = 1'b1;
               ld_full  = 1'b1;
               if (bit_idx == 3'd7) state_n = STOP;
             end
      STOP:  if (cnt == '0) begin
               if (rxs) begin byte_done = 1'b1; state_n = IDLE; end
               else begin ferr = 1'b1; state_n = BRK; end
             end
      BRK:   if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      byte_valid <= byte_done;
      frame_err  <= ferr;
      if (ld_half)         cnt <= HALF_LD;
      else if (ld_full)    cnt <= FULL_LD;
      else if (cnt != '0)  cnt <= cnt - 1'b1;
      if (state != DATA)   bit_idx <= '0;
      else if (shift_en)   bit_idx <= bit_idx + 1'b1;
      if (shift_en)        shreg   <= {rxs, shreg[7:1]};
      if (byte_done)       rx_data <= shreg;
    end
  end

  assign busy = (state != IDLE);

  // Any overflowed line is unmatched regardless of what was stored.
  always_comb begin
    code = 3'd7;
    if (!ovf) begin
      if (str_eq(S_OK, 2, len, line_buf))         code = 3'd1;
      else if (str_eq(S_ERROR, 5, len, line_buf)) code = 3'd2;
      else if (str_eq(S_READY, 5, len, line_buf)) code = 3'd3;
      else if (str_eq(S_SEND, 7, len, line_buf))  code = 3'd4;
      else if (str_eq(S_FAIL, 4, len, line_buf))  code = 3'd5;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_buf   <= '0;
      len        <= '0;
      ovf        <= 1'b0;
      match_pend <= 1'b0;
      resp_code  <= 3'd0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= match_pend;
      match_pend <= 1'b0;
      if (match_pend) begin
        resp_code <= code;
        len       <= '0;
        ovf       <= 1'b0;
      end else if (frame_err) begin
        len <= '0;
        ovf <= 1'b0;
      end else if (byte_valid) begin
        if (rx_data == 8'h0A) begin
          match_pend <= (len != '0) || ovf;
        end else if (rx_data != 8'h0D) begin
          if (len < LEN_MAX) begin
            line_buf[8*len +: 8] <= rx_data;
            len                  <= len + 1'b1;
          end else begin
            ovf <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_comunicaciones_rx.sv
// Directed bench for comunicaciones_rx; a short bit period keeps the run compact.
module tb_comunicaciones_rx;
  localparam int BAUD = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       byte_valid, frame_err, resp_valid, busy;
  logic [2:0] resp_code;

  always #5 clk = ~clk;

  comunicaciones_rx #(.BAUD(BAUD), .MAXLEN(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .byte_valid(byte_valid),
    .frame_err(frame_err), .resp_code(resp_code), .resp_valid(resp_valid), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] bq[$];
  logic [2:0] rq[$];
  int   fe_cnt = 0, first_bv = -1, busy_rise = -1, lf_cyc = -1, rv_cyc = -1;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) begin
      bq.push_back(rx_data);
      if (first_bv < 0) first_bv = cyc;
      if (rx_data == 8'h0A) lf_cyc = cyc;
    end
    if (resp_valid) begin
      rq.push_back(resp_code);
      rv_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (busy && !busy_q && busy_rise < 0) busy_rise = cyc;
    busy_q = busy;
  end

  function automatic logic [2:0] rsp(input int i);
    return (rq.size() > i) ? rq[i] : 3'bx;
  endfunction

  function automatic logic [7:0] byt(input int i);
    return (bq.size() > i) ? bq[i] : 8'hxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bq.delete();
    rq.delete();
    fe_cnt = 0; first_bv = -1; busy_rise = -1; lf_cyc = -1; rv_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BAUD);
    end
    rx = stop;
    tick(BAUD);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    total++; if (rx_data !== 8'h00)   begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_byte_valid got=%b exp=0", byte_valid); end
    total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    total++; if (resp_code !== 3'd0)  begin bad++; $display("FAIL reset_resp_code got=%0d exp=0", resp_code); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
    tick(5);
  endtask

  task automatic test_ok();
    int t0;
    clear_mon();
    t0 = cyc;
    send_byte(8'h4F, 1'b1);
    send_byte(8'h4B, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    tick(8);
    total++; if (busy_rise !== t0 + 3) begin bad++; $display("FAIL ok_busy_rise got=%0d exp=%0d", busy_rise, t0 + 3); end
    total++; if (first_bv !== t0 + 3 + BAUD/2 + 9*BAUD)
      begin bad++; $display("FAIL ok_first_bv got=%0d exp=%0d", first_bv, t0 + 3 + BAUD/2 + 9*BAUD); end
    total++; if (bq.size() !== 4) begin bad++; $display("FAIL ok_byte_count got=%0d exp=4", bq.size()); end
    total++; if ({byt(0), byt(1), byt(2), byt(3)} !== 32'h4F4B0D0A)
      begin bad++; $display("FAIL ok_bytes got=%h exp=4f4b0d0a", {byt(0), byt(1), byt(2), byt(3)}); end
    total++; if (rq.size() !== 1) begin bad++; $display("FAIL ok_resp_count got=%0d exp=1", rq.size()); end
    total++; if (rsp(0) !== 3'd1) begin bad++; $display("FAIL ok_code got=%0d exp=1", rsp(0)); end
    total++; if (rv_cyc - lf_cyc !== 2) begin bad++; $display("FAIL ok_resp_latency got=%0d exp=2", rv_cyc - lf_cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ok_busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_sequence();
    clear_mon();
    send_str("ERROR");   send_byte(8'h0A, 1'b1);
    send_str("SEND OK"); send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
    send_str("xyz");     send_byte(8'h0A, 1'b1);
    tick(8);
    total++; if (rq.size() !== 3) begin bad++; $display("FAIL seq_resp_count got=%0d exp=3", rq.size()); end
    total++; if ({rsp(0), rsp(1), rsp(2)} !== {3'd2, 3'd4, 3'd7})
      begin bad++; $display("FAIL seq_codes got=%0d,%0d,%0d exp=2,4,7", rsp(0), rsp(1), rsp(2)); end
    tick(50);
    total++; if (resp_code !== 3'd7) begin bad++; $display("FAIL seq_code_hold got=%0d exp=7", resp_code); end
  endtask

  task automatic test_blank();
    clear_mon();
    send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
    tick(8);
    total++; if (bq.size() !== 4) begin bad++; $display("FAIL blank_byte_count got=%0d exp=4", bq.size()); end
    total++; if (rq.size() !== 0) begin bad++; $display("FAIL blank_resp_count got=%0d exp=0", rq.size()); end
    total++; if (resp_code !== 3'd7) begin bad++; $display("FAIL blank_code_hold got=%0d exp=7", resp_code); end
  endtask

  task automatic test_overflow();
    clear_mon();
    for (int i = 0; i < 20; i++) send_byte(8'h41, 1'b1);
    send_byte(8'h0A, 1'b1);
    tick(8);
    total++; if (bq.size() !== 21) begin bad++; $display("FAIL ovf_byte_count got=%0d exp=21", bq.size()); end
    total++; if (rq.size() !== 1 || rsp(0) !== 3'd7)
      begin bad++; $display("FAIL ovf_code got=%0d n=%0d exp=7 n=1", rsp(0), rq.size()); end
    clear_mon();
    send_str("OK"); send_byte(8'h0A, 1'b1);
    tick(8);
    total++; if (rq.size() !== 1 || rsp(0) !== 3'd1)
      begin bad++; $display("FAIL ovf_recover_code got=%0d n=%0d exp=1 n=1", rsp(0), rq.size()); end
  endtask

  task automatic test_glitch_frame();
    clear_mon();
    rx = 1'b0;
    tick(10);
    rx = 1'b1;
    tick(40);
    total++; if (bq.size() !== 0 || fe_cnt !== 0)
      begin bad++; $display("FAIL glitch_pulses got_bytes=%0d got_ferr=%0d exp=0,0", bq.size(), fe_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b exp=0", busy); end
    send_byte(8'h55, 1'b0);
    tick(2 * BAUD);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy got=%b exp=1", busy); end
    total++; if (fe_cnt !== 1) begin bad++; $display("FAIL break_ferr_count got=%0d exp=1", fe_cnt); end
    total++; if (bq.size() !== 0) begin bad++; $display("FAIL break_byte_count got=%0d exp=0", bq.size()); end
    rx = 1'b1;
    tick(5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_release_busy got=%b exp=0", busy); end
    send_str("OK"); send_byte(8'h0A, 1'b1);
    tick(8);
    total++; if (rq.size() !== 1 || rsp(0) !== 3'd1)
      begin bad++; $display("FAIL break_recover_code got=%0d n=%0d exp=1 n=1", rsp(0), rq.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] k;
    k = 8'h4B;
    clear_mon();
    send_byte(8'h4F, 1'b1);
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 4; i++) begin
      rx = k[i];
      tick(BAUD);
    end
    rx = k[4];
    tick(BAUD / 2);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (rx_data !== 8'h00)  begin bad++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data); end
    total++; if (resp_code !== 3'd0) begin bad++; $display("FAIL midrst_resp_code got=%0d exp=0", resp_code); end
    rx = 1'b1;
    tick(3);
    total++; if ({byte_valid, frame_err, resp_valid, busy} !== 4'b0000)
      begin bad++; $display("FAIL midrst_hold got=%b exp=0000", {byte_valid, frame_err, resp_valid, busy}); end
    rst = 1'b1;
    tick(2 * BAUD);
    total++; if (bq.size() !== 1 || rq.size() !== 0)
      begin bad++; $display("FAIL midrst_partial got_bytes=%0d got_resp=%0d exp=1,0", bq.size(), rq.size()); end
    clear_mon();
    send_str("OK"); send_byte(8'h0A, 1'b1);
    tick(8);
    total++; if (rq.size() !== 1 || rsp(0) !== 3'd1)
      begin bad++; $display("FAIL midrst_resend_code got=%0d n=%0d exp=1 n=1", rsp(0), rq.size()); end
  endtask

  initial begin
    test_reset();
    test_ok();
    test_sequence();
    test_blank();
    test_overflow();
    test_glitch_frame();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
